// File: rtl/isa_decoder.sv
// Instruction field/control decoder with an NREG x XLEN register file:
// one synchronous write port, two combinational read ports with write-through bypass.

module isa_reg_cell #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module isa_decoder #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic            wb_en,
  input  logic [3:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [15:0]     imm,
  output logic [XLEN-1:0] imm_sext,
  output logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] rs2_value,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src_imm,
  output logic            branch,
  output logic            jump,
  output logic            halt
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_ADDI = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_BEQ = 4'hA, OP_BNE  = 4'hB,
    OP_LUI  = 4'hC, OP_JAL  = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF
  } op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src_imm;
    logic branch;
    logic jump;
    logic halt;
  } ctrl_t;

  // Field extraction
  assign opcode   = instruction[31:28];
  assign rd       = instruction[27:24];
  assign rs1      = instruction[23:20];
  assign rs2      = instruction[19:16];
  assign imm      = instruction[15:0];
  assign imm_sext = {{(XLEN-16){imm[15]}}, imm};

  // Register file: entry 0 is hardwired to zero, so no cell is built for it
  logic [NREG-1:0][XLEN-1:0] regs;
  logic                      wr_ok;

  assign wr_ok   = wb_en && (wb_rd != 4'd0);
  assign regs[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      isa_reg_cell #(.XLEN(XLEN)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok && (wb_rd == 4'(g))),
        .d     (wb_data),
        .q     (regs[g])
      );
    end
  endgenerate

  // Bypass only when the write will actually land; under reset it is dropped
  logic byp1, byp2;
  assign byp1 = rst_n && wr_ok && (wb_rd == rs1);
  assign byp2 = rst_n && wr_ok && (wb_rd == rs2);

  assign rs1_value = byp1 ? wb_data : regs[rs1];
  assign rs2_value = byp2 ? wb_data : regs[rs2];

  // Control decode
  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (op_e'(opcode))
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SLL, OP_SRL:      ctrl.reg_write = 1'b1;
      OP_ADDI, OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_BEQ, OP_BNE:              ctrl.branch = 1'b1;
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OP_HALT:                     ctrl.halt = 1'b1;
      default:                     ctrl = '0;
    endcase
  end

  // A write to r0 would be discarded anyway, so do not advertise one
  assign reg_write   = ctrl.reg_write && (rd != 4'd0);
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign alu_src_imm = ctrl.alu_src_imm;
  assign branch      = ctrl.branch;
  assign jump        = ctrl.jump;
  assign halt        = ctrl.halt;

endmodule

// File: tb/tb_isa_decoder.sv
// Directed bench for isa_decoder: decode table sweep plus register-file sequences.

module tb_isa_decoder;
  localparam int XLEN = 32;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     instruction;
  logic            wb_en;
  logic [3:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [3:0]      opcode, rd, rs1, rs2;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_sext, rs1_value, rs2_value;
  logic            reg_write, mem_read, mem_write, alu_src_imm, branch, jump, halt;

  int total = 0;
  int bad   = 0;

  isa_decoder #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .imm_sext    (imm_sext),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src_imm (alu_src_imm),
    .branch      (branch),
    .jump        (jump),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  // {reg_write, mem_read, mem_write, alu_src_imm, branch, jump, halt}
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  e_op, e_rd, e_rs1, e_rs2;
    logic [15:0] e_imm;
    logic [31:0] e_sext;
    logic [6:0]  e_ctrl;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input logic [3:0] a, input logic [3:0] b);
    instruction = {4'hE, 4'h0, a, b, 16'h0000};
    #1;
  endtask

  initial begin
    // opcode sweep, rd=1, rs1=2, rs2=3, assorted immediates
    vecs[0]  = '{32'h0123_007B, 4'h0, 4'h1, 4'h2, 4'h3, 16'h007B, 32'h0000_007B, 7'b1000000};
    vecs[1]  = '{32'h1123_FFFE, 4'h1, 4'h1, 4'h2, 4'h3, 16'hFFFE, 32'hFFFF_FFFE, 7'b1000000};
    vecs[2]  = '{32'h2123_7FFF, 4'h2, 4'h1, 4'h2, 4'h3, 16'h7FFF, 32'h0000_7FFF, 7'b1000000};
    vecs[3]  = '{32'h3123_8000, 4'h3, 4'h1, 4'h2, 4'h3, 16'h8000, 32'hFFFF_8000, 7'b1000000};
    vecs[4]  = '{32'h4123_0000, 4'h4, 4'h1, 4'h2, 4'h3, 16'h0000, 32'h0000_0000, 7'b1000000};
    vecs[5]  = '{32'h5123_FFFF, 4'h5, 4'h1, 4'h2, 4'h3, 16'hFFFF, 32'hFFFF_FFFF, 7'b1000000};
    vecs[6]  = '{32'h6123_0001, 4'h6, 4'h1, 4'h2, 4'h3, 16'h0001, 32'h0000_0001, 7'b1000000};
    vecs[7]  = '{32'h7123_1234, 4'h7, 4'h1, 4'h2, 4'h3, 16'h1234, 32'h0000_1234, 7'b1001000};
    vecs[8]  = '{32'h8123_A5A5, 4'h8, 4'h1, 4'h2, 4'h3, 16'hA5A5, 32'hFFFF_A5A5, 7'b1101000};
    vecs[9]  = '{32'h9123_0010, 4'h9, 4'h1, 4'h2, 4'h3, 16'h0010, 32'h0000_0010, 7'b0011000};
    vecs[10] = '{32'hA123_FFF0, 4'hA, 4'h1, 4'h2, 4'h3, 16'hFFF0, 32'hFFFF_FFF0, 7'b0000100};
    vecs[11] = '{32'hB123_0020, 4'hB, 4'h1, 4'h2, 4'h3, 16'h0020, 32'h0000_0020, 7'b0000100};
    vecs[12] = '{32'hC123_4000, 4'hC, 4'h1, 4'h2, 4'h3, 16'h4000, 32'h0000_4000, 7'b1001000};
    vecs[13] = '{32'hD123_C000, 4'hD, 4'h1, 4'h2, 4'h3, 16'hC000, 32'hFFFF_C000, 7'b1000010};
    vecs[14] = '{32'hE123_0000, 4'hE, 4'h1, 4'h2, 4'h3, 16'h0000, 32'h0000_0000, 7'b0000000};
    vecs[15] = '{32'hF123_0000, 4'hF, 4'h1, 4'h2, 4'h3, 16'h0000, 32'h0000_0000, 7'b0000001};
    // rd=0 suppresses reg_write only
    vecs[16] = '{32'h70AB_0005, 4'h7, 4'h0, 4'hA, 4'hB, 16'h0005, 32'h0000_0005, 7'b0001000};
    vecs[17] = '{32'h8045_0000, 4'h8, 4'h0, 4'h4, 4'h5, 16'h0000, 32'h0000_0000, 7'b0101000};
    vecs[18] = '{32'hD0FF_0000, 4'hD, 4'h0, 4'hF, 4'hF, 16'h0000, 32'h0000_0000, 7'b0000010};
    vecs[19] = '{32'h0F9C_8001, 4'h0, 4'hF, 4'h9, 4'hC, 16'h8001, 32'hFFFF_8001, 7'b1000000};

    rst_n = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    instruction = 32'hE000_0000;
    tick(); tick();

    // reset state: every register reads zero
    for (int i = 0; i < NREG; i++) begin
      set_rs(4'(i), 4'(NREG-1-i));
      chk($sformatf("rst_rs1[%0d]", i), rs1_value, 0);
      chk($sformatf("rst_rs2[%0d]", i), rs2_value, 0);
    end
    rst_n = 1'b1;
    tick();

    // decode table
    for (int i = 0; i < 20; i++) begin
      instruction = vecs[i].instr;
      #1;
      chk($sformatf("v%0d_op", i),   opcode,   vecs[i].e_op);
      chk($sformatf("v%0d_rd", i),   rd,       vecs[i].e_rd);
      chk($sformatf("v%0d_rs1", i),  rs1,      vecs[i].e_rs1);
      chk($sformatf("v%0d_rs2", i),  rs2,      vecs[i].e_rs2);
      chk($sformatf("v%0d_imm", i),  imm,      vecs[i].e_imm);
      chk($sformatf("v%0d_sext", i), imm_sext, vecs[i].e_sext);
      chk($sformatf("v%0d_ctrl", i),
          {reg_write, mem_read, mem_write, alu_src_imm, branch, jump, halt}, vecs[i].e_ctrl);
    end

    // write r3=45, r5=77 as single-cycle pulses, then read both
    instruction = 32'hE000_0000;
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 45; tick();
    wb_rd = 4'd5; wb_data = 77; tick();
    wb_en = 1'b0; wb_rd = 4'd0; wb_data = 0;
    instruction = {4'h0, 4'h1, 4'h3, 4'h5, 16'd123};
    #1;
    chk("add_op",   opcode,    0);
    chk("add_rd",   rd,        1);
    chk("add_imm",  imm,       123);
    chk("add_rs1v", rs1_value, 45);
    chk("add_rs2v", rs2_value, 77);
    chk("add_rw",   reg_write, 1);
    repeat (3) tick();
    chk("persist_r3", rs1_value, 45);
    chk("persist_r5", rs2_value, 77);

    // same-cycle bypass on rs1, then stored value after the edge
    set_rs(4'd4, 4'd5);
    chk("pre_r4", rs1_value, 0);
    wb_en = 1'b1; wb_rd = 4'd4; wb_data = 99; #1;
    chk("byp_rs1",   rs1_value, 99);
    chk("byp_rs2no", rs2_value, 77);
    tick();
    wb_en = 1'b0; #1;
    chk("post_r4", rs1_value, 99);

    // both ports bypass independently, also when pointing at the same reg
    set_rs(4'd7, 4'd7);
    wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'hDEAD_BEEF; #1;
    chk("byp2_rs1", rs1_value, 32'hDEAD_BEEF);
    chk("byp2_rs2", rs2_value, 32'hDEAD_BEEF);
    set_rs(4'd3, 4'd7); #1;
    chk("byp2_rs2only", rs2_value, 32'hDEAD_BEEF);
    chk("byp2_rs1keep", rs1_value, 45);
    tick();
    wb_en = 1'b0;

    // r0 is immutable and never bypassed
    wb_en = 1'b1; wb_rd = 4'd0; wb_data = 55;
    set_rs(4'd0, 4'd0);
    chk("r0_byp", rs1_value, 0);
    tick();
    wb_en = 1'b0; #1;
    chk("r0_rs1", rs1_value, 0);
    chk("r0_rs2", rs2_value, 0);
    instruction = 32'h7000_0000; #1;
    chk("addi_rd0_rw", reg_write, 0);

    // reset clears contents and drops a concurrent write
    set_rs(4'd3, 4'd6);
    chk("pre_rst_r3", rs1_value, 45);
    rst_n = 1'b0; wb_en = 1'b1; wb_rd = 4'd6; wb_data = 88;
    tick();
    chk("in_rst_r3", rs1_value, 0);
    instruction = 32'h9123_FFFE; #1;
    chk("in_rst_ctrl", {reg_write, mem_read, mem_write, alu_src_imm, branch, jump, halt}, 7'b0011000);
    chk("in_rst_sext", imm_sext, 32'hFFFF_FFFE);
    rst_n = 1'b1; wb_en = 1'b0; wb_rd = 4'd0; wb_data = 0;
    set_rs(4'd3, 4'd6);
    chk("post_rst_r3", rs1_value, 0);
    chk("post_rst_r6", rs2_value, 0);
    set_rs(4'd4, 4'd7);
    chk("post_rst_r4", rs1_value, 0);
    chk("post_rst_r7", rs2_value, 0);

    // register file still writable after reset
    wb_en = 1'b1; wb_rd = 4'd15; wb_data = 32'h1234_5678; tick();
    wb_en = 1'b0;
    set_rs(4'd15, 4'd14);
    chk("r15", rs1_value, 32'h1234_5678);
    chk("r14", rs2_value, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/isa_decoder.md
ISA_DECODER -- requirements
Module: isa_decoder

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, as the register and data width.
REQ-002 The block SHALL have parameter NREG, default 16, as the register count, indexed by 4 bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-005 The block SHALL have port instruction, input, 32, the instruction word to decode.
REQ-006 The block SHALL have port wb_en, input, 1, the register write-back enable.
REQ-007 The block SHALL have port wb_rd, input, 4, the write-back destination index.
REQ-008 The block SHALL have port wb_data, input, XLEN, the write-back data.
REQ-009 The block SHALL have port opcode, output, 4, equal to instruction[31:28].
REQ-010 The block SHALL have port rd, output, 4, equal to instruction[27:24].
REQ-011 The block SHALL have ports rs1 and rs2, output, 4 each, equal to instruction[23:20] and instruction[19:16].
REQ-012 The block SHALL have port imm, output, 16, equal to instruction[15:0].
REQ-013 The block SHALL have port imm_sext, output, XLEN, equal to imm sign-extended.
REQ-014 The block SHALL have ports rs1_value and rs2_value, output, XLEN each, the register read data.
REQ-015 The block SHALL have control outputs reg_write, mem_read, mem_write, alu_src_imm, branch, jump and halt, output, 1 each.

Function
REQ-016 The block SHALL contain an NREG x XLEN register file with one write port and two asynchronous read ports.
REQ-017 Field outputs (opcode, rd, rs1, rs2, imm, imm_sext) SHALL be purely combinational from instruction, with zero-cycle latency.
REQ-018 rs1_value and rs2_value SHALL combinationally reflect register[rs1] and register[rs2] in the same cycle.
REQ-019 On a rising clk edge with rst_n=1, wb_en=1 and wb_rd!=0, register[wb_rd] SHALL be loaded with wb_data.
REQ-020 Register 0 SHALL always read 0; writes to index 0 SHALL be ignored.
REQ-021 Write-through bypass: when wb_en=1, wb_rd!=0 and wb_rd equals rs1 or rs2, the matching read output SHALL present wb_data in that same cycle; both ports bypass independently.
REQ-022 Opcode map (control outputs not listed are 0):
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: reg_write.
- 7 ADDI: reg_write, alu_src_imm.
- 8 LW: reg_write, mem_read, alu_src_imm.
- 9 SW: mem_write, alu_src_imm.
- A BEQ, B BNE: branch.
- C LUI: reg_write, alu_src_imm.
- D JAL: reg_write, jump.
- E NOP: all 0.
- F HALT: halt.
REQ-023 reg_write SHALL be forced to 0 whenever rd=0.
REQ-024 Control outputs SHALL be combinational from opcode and rd only, independent of register contents.

Reset
REQ-025 On a rising clk edge with rst_n=0, all registers SHALL clear to 0 and any write that cycle SHALL be suppressed.
REQ-026 During reset, field and control outputs SHALL still follow instruction combinationally; read outputs SHALL show cleared contents from the first edge after rst_n falls.
REQ-027 Register contents after reset release SHALL persist until written.

Verification
REQ-028 Write r3=45 and r5=77 (wb_en pulses of one cycle each), then instruction={0,1,3,5,16'd123} -> opcode=0, rd=1, imm=123, rs1_value=45, rs2_value=77, reg_write=1.
REQ-029 instruction with imm=16'hFFFE -> imm_sext=32'hFFFFFFFE; with imm=16'h7FFF -> 32'h00007FFF.
REQ-030 wb_en=1, wb_rd=4, wb_data=99 while rs1=4 -> rs1_value=99 in the same cycle; after the edge, with wb_en=0 -> still 99.
REQ-031 Write r0=55 -> rs1=0 reads 0; opcode 7 with rd=0 -> reg_write=0.
REQ-032 Load r3=45, then rst_n=0 for one edge -> rs1=3 reads 0; a write presented during that reset edge is not stored.
REQ-033 Sweep opcode 0..F -> control outputs match the REQ-022 table exactly.
